// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg
//   Shared definitions for the PC fetch stage:
//     - fetch_state_e : FSM state encoding (BOOT / RUN)
//     - PC_INC        : sequential fetch increment in bytes
//     - sext_shift2() : sign-extend a 16-bit branch immediate and scale it
//                       to a byte offset. The EX branch adder uses the same helper.
package pc_fetch_ctrl_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    localparam int PC_INC = 4;

    // Returns a 64-bit result so that any address width up to 64 can take
    // its own low slice. The caller truncates with a size cast.
    function automatic logic [63:0] sext_shift2(input logic [15:0] imm);
        return {{46{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if
//   Groups the signals between the PC fetch stage and its neighbours.
//   - master: hazard unit / ID / EX side. Drives stall, branch and jump info.
//             Observes the fetch address, flush and counters.
//   - slave : pc_fetch_ctrl itself.
//   Handshake: imem_req is a valid-only strobe with no ready. Whenever
//   imem_req=1, pc_out is a fetch address and the instruction memory must
//   accept it in that cycle. stall never back-pressures the memory; it only
//   holds pc_out, so the same address is presented again.
//   state_dbg exposes the FSM state for observation.
interface pc_fetch_ctrl_if #(
    parameter int WIDTH = 32
);
    import pc_fetch_ctrl_pkg::*;

    logic               stall;
    logic               branch_taken;
    logic [WIDTH-1:0]   branch_base;
    logic [15:0]        branch_offset;
    logic               jump;
    logic [25:0]        jump_index;

    logic [WIDTH-1:0]   pc_out;
    logic [WIDTH-1:0]   pc_plus4;
    logic               imem_req;
    logic               flush;
    logic [15:0]        redirect_cnt;
    fetch_state_e       state_dbg;

    modport master (
        output stall, branch_taken, branch_base, branch_offset, jump, jump_index,
        input  pc_out, pc_plus4, imem_req, flush, redirect_cnt, state_dbg
    );

    modport slave (
        input  stall, branch_taken, branch_base, branch_offset, jump, jump_index,
        output pc_out, pc_plus4, imem_req, flush, redirect_cnt, state_dbg
    );

endinterface

// File: rtl/pc_fetch_ctrl_target_calc.sv
// pc_target_calc
//   Purely combinational next-PC candidate generator.
//   Inputs : pc (current PC), branch_base (PC+4 of the branch instruction),
//            branch_offset (raw 16-bit immediate), jump_index (instr[25:0]).
//   Outputs: pc_plus4, branch_target, jump_target. All are word aligned and
//            wrap modulo 2^WIDTH.
//   WIDTH must lie between 29 and 64, because the jump target keeps
//   pc_plus4 bits above 27.
module pc_target_calc
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] branch_base,
    input  logic [15:0]      branch_offset,
    input  logic [25:0]      jump_index,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] jump_target
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    logic [WIDTH-1:0] inc_sum;
    logic [WIDTH-1:0] br_sum;

    always_comb begin
        inc_sum       = pc + WIDTH'(PC_INC);
        br_sum        = branch_base + WIDTH'(sext_shift2(branch_offset));
        // Clear the low bits so pc_out stays word aligned even if a
        // misaligned base is presented.
        pc_plus4      = inc_sum & ALIGN_MASK;
        branch_target = br_sum & ALIGN_MASK;
        jump_target   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   PC stage of the MIPS datapath. Owns the PC register and selects the next PC.
//   Next-PC priority: taken branch > jump (if not flushing) > stall hold > PC+4.
//   Also generates the multi-cycle wrong-path flush and a saturating
//   redirect counter.
//   Ports:
//     clk, rst : clock (rising edge) and asynchronous active-high reset
//     bus      : pc_fetch_ctrl_if.slave. Carries stall, branch_taken,
//                branch_base, branch_offset, jump and jump_index in, and
//                pc_out, pc_plus4, imem_req, flush, redirect_cnt and
//                state_dbg out.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_PC     = '0,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_fetch_ctrl_if.slave       bus
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic             flush_q, flush_d;
    logic             imem_req_q, imem_req_d;
    logic [15:0]      redirect_cnt_q, redirect_cnt_d;
    logic             redirect;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;

    pc_target_calc #(
        .WIDTH (WIDTH)
    ) u_target_calc (
        .pc            (pc_q),
        .branch_base   (bus.branch_base),
        .branch_offset (bus.branch_offset),
        .jump_index    (bus.jump_index),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .jump_target   (jump_target)
    );

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        flush_cnt_d    = flush_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        redirect       = 1'b0;

        // The flush counter free-runs down. stall does not pause it.
        if (flush_cnt_q != 3'd0) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
        end

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (bus.branch_taken) begin
                    // A branch in EX is older than anything in IF/ID.
                    // It beats a stall and a same-cycle jump. A new branch
                    // reloads the counter rather than adding to it.
                    pc_d        = branch_target;
                    flush_cnt_d = FLUSH_LOAD;
                    redirect    = 1'b1;
                end else if (bus.jump && !flush_q) begin
                    // A jump seen while flushing is on the wrong path.
                    pc_d     = jump_target;
                    redirect = 1'b1;
                end else if (!bus.stall) begin
                    pc_d = pc_plus4;
                end
            end
        endcase

        if (redirect && (redirect_cnt_q != 16'hFFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
        end

        flush_d    = (flush_cnt_d != 3'd0);
        imem_req_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= BOOT;
            pc_q           <= RESET_PC;
            flush_cnt_q    <= 3'd0;
            flush_q        <= 1'b0;
            imem_req_q     <= 1'b0;
            redirect_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            flush_cnt_q    <= flush_cnt_d;
            flush_q        <= flush_d;
            imem_req_q     <= imem_req_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.imem_req     = imem_req_q;
    assign bus.flush        = flush_q;
    assign bus.redirect_cnt = redirect_cnt_q;
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl
//   Directed scenarios plus a randomized run for pc_fetch_ctrl.
//   Expected values come from the directed constants and from a behavioural
//   reference model of the fetch rules.
module tb_pc_fetch_ctrl;
    import pc_fetch_ctrl_pkg::*;

    localparam int FLUSH_CYCLES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pc_fetch_ctrl_if #(.WIDTH(32)) bus ();

    pc_fetch_ctrl #(
        .WIDTH        (32),
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_run;
    logic [31:0] m_pc;
    int          m_flush_left;
    int          m_cnt;

    task automatic model_reset();
        m_run        = 1'b0;
        m_pc         = 32'h0;
        m_flush_left = 0;
        m_cnt        = 0;
    endtask

    // Applies one clock edge's worth of fetch rules to the model,
    // using the inputs currently presented.
    task automatic model_edge();
        bit          flushing;
        logic [31:0] p4;
        int          off;
        flushing = (m_flush_left != 0);
        p4       = m_pc + 32'd4;
        if (m_flush_left > 0) m_flush_left--;
        if (!m_run) begin
            m_run = 1'b1;
        end else if (bus.branch_taken) begin
            off          = int'($signed(bus.branch_offset));
            m_pc         = (bus.branch_base + 32'(off * 4)) & 32'hFFFF_FFFC;
            m_flush_left = FLUSH_CYCLES;
            if (m_cnt < 65535) m_cnt++;
        end else if (bus.jump && !flushing) begin
            m_pc = (p4 & 32'hF000_0000) | (32'(bus.jump_index) * 32'd4);
            if (m_cnt < 65535) m_cnt++;
        end else if (!bus.stall) begin
            m_pc = p4;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_base   = 32'h0;
        bus.branch_offset = 16'h0;
        bus.jump          = 1'b0;
        bus.jump_index    = 26'h0;
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_branch(input logic [31:0] base, input logic [15:0] off);
        bus.branch_taken  = 1'b1;
        bus.branch_base   = base;
        bus.branch_offset = off;
        tick();
        idle_inputs();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        model_reset();
        rst = 1'b1;
        #22;
        checks++; if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", bus.pc_out, 32'h0); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", bus.flush); end
        checks++; if (bus.redirect_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", bus.redirect_cnt); end
        checks++; if (bus.state_dbg !== BOOT) begin errors++; $display("FAIL reset_state got %b exp BOOT", bus.state_dbg); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        // BOOT must ignore redirect inputs.
        bus.branch_taken = 1'b1;
        bus.branch_base  = 32'h1000;
        bus.jump         = 1'b1;
        tick();
        idle_inputs();
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL boot_req got %b exp 1", bus.imem_req); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++; if (bus.pc_out !== exp_pc[i]) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, bus.pc_out, exp_pc[i]); end
        end
        checks++; if (bus.pc_plus4 !== 32'h10) begin errors++; $display("FAIL seq_pc_plus4 got %h exp %h", bus.pc_plus4, 32'h10); end
    endtask

    task automatic test_branch();
        int cnt_before;
        do_branch(32'h0F8, 16'h0);
        tick();
        tick();
        checks++; if (bus.pc_out !== 32'h100) begin errors++; $display("FAIL br_setup_pc got %h exp %h", bus.pc_out, 32'h100); end
        cnt_before = m_cnt;
        do_branch(32'h0F8, 16'hFFFE);
        checks++; if (bus.pc_out !== 32'h0F0) begin errors++; $display("FAIL br_pc got %h exp %h", bus.pc_out, 32'h0F0); end
        checks++; if (bus.redirect_cnt !== 16'(cnt_before + 1)) begin errors++; $display("FAIL br_cnt got %0d exp %0d", bus.redirect_cnt, cnt_before + 1); end
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL br_flush1 got %b exp 1", bus.flush); end
        tick();
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL br_flush2 got %b exp 1", bus.flush); end
        tick();
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL br_flush3 got %b exp 0", bus.flush); end
        checks++; if (bus.pc_out !== 32'h0F8) begin errors++; $display("FAIL br_after_pc got %h exp %h", bus.pc_out, 32'h0F8); end
    endtask

    task automatic test_stall_branch();
        bus.stall = 1'b1;
        do_branch(32'h200, 16'h3);
        checks++; if (bus.pc_out !== 32'h20C) begin errors++; $display("FAIL stbr_pc got %h exp %h", bus.pc_out, 32'h20C); end
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc_out !== 32'h20C) begin errors++; $display("FAIL stall_hold[%0d] got %h exp %h", i, bus.pc_out, 32'h20C); end
        end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL stall_req got %b exp 1", bus.imem_req); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL stall_flush got %b exp 0", bus.flush); end
        bus.stall = 1'b0;
        tick();
        checks++; if (bus.pc_out !== 32'h210) begin errors++; $display("FAIL stall_release got %h exp %h", bus.pc_out, 32'h210); end
    endtask

    task automatic test_jump();
        do_branch(32'h8000_0008, 16'h0);
        tick();
        tick();
        checks++; if (bus.pc_out !== 32'h8000_0010) begin errors++; $display("FAIL jmp_setup got %h exp %h", bus.pc_out, 32'h8000_0010); end
        bus.jump       = 1'b1;
        bus.jump_index = 26'h0000040;
        tick();
        idle_inputs();
        checks++; if (bus.pc_out !== 32'h8000_0100) begin errors++; $display("FAIL jmp_pc got %h exp %h", bus.pc_out, 32'h8000_0100); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL jmp_flush got %b exp 0", bus.flush); end
        do_branch(32'h8000_0200, 16'h0);
        bus.jump       = 1'b1;
        bus.jump_index = 26'h0000040;
        tick();
        idle_inputs();
        checks++; if (bus.pc_out !== 32'h8000_0204) begin errors++; $display("FAIL jmp_in_flush got %h exp %h", bus.pc_out, 32'h8000_0204); end
        // Branch and jump together: branch must win.
        tick();
        bus.jump       = 1'b1;
        bus.jump_index = 26'h0000040;
        do_branch(32'h0000_0400, 16'h1);
        checks++; if (bus.pc_out !== 32'h0000_0404) begin errors++; $display("FAIL br_over_jmp got %h exp %h", bus.pc_out, 32'h0000_0404); end
    endtask

    task automatic test_wrap();
        tick();
        tick();
        do_branch(32'hFFFF_FFFC, 16'h0);
        checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp %h", bus.pc_plus4, 32'h0); end
        tick();
        checks++; if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp %h", bus.pc_out, 32'h0); end
        do_branch(32'hFFFF_FFF0, 16'h0008);
        checks++; if (bus.pc_out !== 32'h10) begin errors++; $display("FAIL wrap_br got %h exp %h", bus.pc_out, 32'h10); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.branch_taken  = ($urandom_range(0, 5) == 0);
            bus.jump          = ($urandom_range(0, 4) == 0);
            bus.stall         = ($urandom_range(0, 3) == 0);
            bus.branch_base   = $urandom;
            bus.branch_offset = 16'($urandom);
            bus.jump_index    = 26'($urandom);
            tick();
            checks++; if (bus.pc_out !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, bus.pc_out, m_pc); end
            checks++; if (bus.pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4[%0d] got %h exp %h", i, bus.pc_plus4, m_pc + 32'd4); end
            checks++; if (bus.flush !== (m_flush_left != 0)) begin errors++; $display("FAIL rnd_flush[%0d] got %b exp %b", i, bus.flush, m_flush_left != 0); end
            checks++; if (bus.redirect_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, bus.redirect_cnt, m_cnt); end
            checks++; if (bus.imem_req !== m_run) begin errors++; $display("FAIL rnd_req[%0d] got %b exp %b", i, bus.imem_req, m_run); end
        end
        idle_inputs();
    endtask

    task automatic test_branch_reload();
        tick();
        tick();
        do_branch(32'h300, 16'h0);
        tick();
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL reload_pre got %b exp 1", bus.flush); end
        do_branch(32'h400, 16'h0);
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL reload_a got %b exp 1", bus.flush); end
        tick();
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL reload_b got %b exp 1", bus.flush); end
        tick();
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reload_c got %b exp 0", bus.flush); end
    endtask

    task automatic test_rst_mid_flush();
        do_branch(32'h500, 16'h0);
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", bus.flush); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL rstmid_pc got %h exp %h", bus.pc_out, 32'h0); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rstmid_flush got %b exp 0", bus.flush); end
        checks++; if (bus.redirect_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_cnt got %h exp 0", bus.redirect_cnt); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b exp 0", bus.imem_req); end
        #1 rst = 1'b0;
        model_reset();
        tick();
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rstmid_post_flush got %b exp 0", bus.flush); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rstmid_post_req got %b exp 1", bus.imem_req); end
    endtask

    task automatic test_saturation();
        bus.branch_taken  = 1'b1;
        bus.branch_base   = 32'h600;
        bus.branch_offset = 16'h0;
        for (int i = 0; i < 65540; i++) begin
            tick();
            if (i == 65533) begin
                checks++; if (bus.redirect_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h exp %h", bus.redirect_cnt, 16'hFFFE); end
            end
        end
        idle_inputs();
        checks++; if (bus.redirect_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %h exp %h", bus.redirect_cnt, 16'hFFFF); end
        bus.jump       = 1'b1;
        bus.jump_index = 26'h1;
        tick();
        tick();
        idle_inputs();
        checks++; if (bus.redirect_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp %h", bus.redirect_cnt, 16'hFFFF); end
        checks++; if (bus.redirect_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL sat_model got %h exp %h", bus.redirect_cnt, 16'(m_cnt)); end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall_branch();
        test_jump();
        test_wrap();
        test_random();
        test_branch_reload();
        test_rst_mid_flush();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter stage of the MIPS datapath, directly downstream of the branch-decision block.
- Consumes the branch-taken bit (`zero & branch`), branch offset/base from EX, and the jump fields from ID.
- Owns the PC register and selects next PC. Produces the instruction-memory request and a multi-cycle flush that squashes wrong-path instructions in IF/ID and ID/EX.

Parameters:
- WIDTH, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- FLUSH_CYCLES, 2, number of cycles flush stays high after a taken branch (1..7).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit hold request (load-use); holds PC.
- branch_taken  input  1  branch decision from EX (`zero & branch`).
- branch_base  input  WIDTH  PC+4 of the branch instruction, from ID/EX.
- branch_offset  input  16  raw immediate of the branch instruction.
- jump  input  1  J-type instruction decoded in ID.
- jump_index  input  26  instr[25:0] of the jump.
- pc_out  output  WIDTH  current fetch address.
- pc_plus4  output  WIDTH  pc_out + 4, combinational.
- imem_req  output  1  fetch valid this cycle.
- flush  output  1  squash IF/ID and ID/EX at the next edge.
- redirect_cnt  output  16  saturating count of taken branches plus jumps.

Behaviour:
- Reset (async, any time, including mid-flush): pc_out=RESET_PC, flush=0, flush counter=0, redirect_cnt=0, imem_req=0, state=BOOT.
- FSM states:
  - BOOT: imem_req=0, PC held. Always goes to RUN at the next edge.
  - RUN: imem_req=1. No other states exist.
- Next-PC priority in RUN, evaluated each edge:
  1. branch_taken=1 -> pc_out <= branch_base + (sext(branch_offset) << 2).
  2. else jump=1 and flush=0 -> pc_out <= {pc_plus4[31:28], jump_index, 2'b00}.
  3. else stall=1 -> pc_out unchanged.
  4. else pc_out <= pc_plus4.
- In BOOT, branch_taken, jump and stall are ignored.
- Arithmetic: all adds are modulo 2^WIDTH.
  - 0xFFFF_FFFC + 4 = 0x0000_0000.
  - Branch target wraps the same way.
  - Result bits [1:0] forced to 0, so pc_out[1:0] is always 0.
- Branch overrides stall: a taken branch in EX is older than the stalled ID instruction.
- Branch overrides jump in the same cycle; the jump is on the wrong path.
- Jump while flush=1 is ignored: that instruction is being squashed.
- Flush counter:
  - At an edge with branch_taken=1 in RUN, load the counter with FLUSH_CYCLES.
  - Otherwise, if nonzero, decrement by 1.
  - flush = (counter != 0), registered.
  - A taken branch while flush=1 reloads the counter; it does not accumulate.
  - stall does not pause the counter.
- Jump redirect does not assert flush. The single delay-slot instruction in IF is killed by the decoder's existing IF.Flush path, outside this block.
- redirect_cnt:
  - Increments by 1 at each edge where rule 1 or rule 2 is applied.
  - Saturates at 16'hFFFF.
  - Reset only by rst.
- Latency: a redirect input sampled at edge N gives the new pc_out after edge N. flush is high from after edge N through FLUSH_CYCLES cycles.

Decomposition:
- Shared package holds:
  - the FSM state encoding (BOOT=1'b0, RUN=1'b1);
  - the PC_INC constant (4);
  - the sign-extend-shift helper, shared with the EX branch adder.
- One natural sub-module, `pc_target_calc`: purely combinational, computes pc_plus4, the branch target and the jump target. The sequential PC register, FSM, flush counter and redirect counter stay in pc_fetch_ctrl.

Test Plan:
- Reset release -> cycle 0: pc_out=0, imem_req=0. Cycle 1: imem_req=1. Then pc_out steps 0, 4, 8, 0xC on successive edges.
- At pc_out=0x100: branch_taken=1, branch_base=0x0F8, offset=16'hFFFE -> next pc_out=0x0F0; flush high exactly 2 cycles; redirect_cnt=1.
- stall=1 and branch_taken=1 same cycle, base=0x200, offset=3 -> pc_out=0x20C; with stall=1 and no branch, pc_out held for 3 cycles.
- jump=1, jump_index=26'h0000040 at pc_out=0x8000_0010 -> pc_out=0x8000_0100, flush stays 0. Repeat with jump during flush=1 -> jump ignored, PC increments.
- pc_out=0xFFFF_FFFC, no events -> pc_out=0x0000_0000. Assert rst mid-flush -> pc_out, flush and redirect_cnt clear immediately, without a clock edge.
- Issue 65540 taken branches -> redirect_cnt sticks at 16'hFFFF. A second branch while flush=1 -> flush extends to 2 cycles after the second branch.
